// File: rtl/btb_pkg.sv
// ============================================================================
// Package : btb_pkg
// Shared types and constants for the branch target buffer: the entry
// layout for the default geometry, 2-bit-style counter initial values
// generalised to any counter width, and the statistics counter width.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package btb_pkg;

  localparam int STAT_W     = 32;

  localparam int BTB_DATA_W = 64;
  localparam int BTB_TAG_W  = 8;
  localparam int BTB_CNT_W  = 2;

  // One table entry in the default geometry
  typedef struct packed {
    logic                  valid;
    logic [BTB_TAG_W-1:0]  tag;
    logic [BTB_DATA_W-1:0] target;
    logic [BTB_CNT_W-1:0]  cnt;
  } btb_entry_t;

  // Weakly-taken: MSB set, all lower bits clear
  function automatic logic [31:0] cnt_weak_taken(input int cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

  // Weakly-not-taken: MSB clear, all lower bits set (zero when cnt_w == 1)
  function automatic logic [31:0] cnt_weak_not_taken(input int cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Saturating up/down counter with a synchronous load, used as the
// per-entry direction predictor of the branch target buffer.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int               CNT_W   = 2,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Load has priority; increment/decrement stop at all-ones / zero
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_dec && (r_count != {CNT_W{1'b0}})) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// ============================================================================
// Module  : branch_target_buffer
// Direct-mapped, flop-based BTB with per-entry saturating counters.
// Combinational lookup, single-cycle update, no update->lookup bypass.
// Optional macro BRANCH_TARGET_BUFFER_STATS_EN adds update/mispredict
// statistics outputs.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_pc,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [DATA_W-1:0] upd_target,
  input  logic              upd_pred
`ifdef BRANCH_TARGET_BUFFER_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  localparam int               IDX_W = $clog2(ENTRIES);
  localparam int               TAG_HI = IDX_W + TAG_W + 1;
  localparam logic [CNT_W-1:0] C_WT  = CNT_W'(cnt_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] C_WNT = CNT_W'(cnt_weak_not_taken(CNT_W));

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [DATA_W-1:0]  r_target [ENTRIES];
  logic [CNT_W-1:0]   w_cnt    [ENTRIES];

  logic [IDX_W-1:0]   w_lk_idx, w_upd_idx;
  logic [TAG_W-1:0]   w_lk_tag, w_upd_tag;
  logic               w_lk_hit, w_upd_hit, w_upd;
  logic [ENTRIES-1:0] w_sel;

  assign w_lk_idx  = lookup_pc[IDX_W+1:2];
  assign w_lk_tag  = lookup_pc[TAG_HI:IDX_W+2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[TAG_HI:IDX_W+2];

  // Lookup reads the registered table only, so a same-cycle update is not seen
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign pred_taken = w_lk_hit && w_cnt[w_lk_idx][CNT_W-1];
  assign pred_pc    = pred_taken ? r_target[w_lk_idx] : '0;

  assign w_upd     = upd_valid && enable;
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // One-hot entry select for the accepted update
  always_comb begin
    w_sel = '0;
    if (w_upd) begin
      w_sel[w_upd_idx] = 1'b1;
    end
  end

  // Valid/tag written only on allocation; target written on any taken update
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_sel[i] && upd_taken) begin
          r_target[i] <= upd_target;
          if (!w_upd_hit) begin
            r_valid[i] <= 1'b1;
            r_tag[i]   <= w_upd_tag;
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      sat_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (C_WNT)
      ) u_cnt (
        .clk        (clk),
        .arst_n     (arst_n),
        .i_inc      (w_sel[gi] && w_upd_hit && upd_taken),
        .i_dec      (w_sel[gi] && w_upd_hit && !upd_taken),
        .i_load     (w_sel[gi] && !w_upd_hit && upd_taken),
        .i_load_val (C_WT),
        .o_count    (w_cnt[gi])
      );
    end
  endgenerate

`ifdef BRANCH_TARGET_BUFFER_STATS_EN
  logic [STAT_W-1:0] r_stat_upd;
  logic [STAT_W-1:0] r_stat_mis;

  // Saturating counts of accepted updates and of mispredicted ones
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_stat_upd <= '0;
      r_stat_mis <= '0;
    end else if (w_upd) begin
      if (r_stat_upd != {STAT_W{1'b1}}) begin
        r_stat_upd <= r_stat_upd + STAT_W'(1);
      end
      if ((upd_pred != upd_taken) && (r_stat_mis != {STAT_W{1'b1}})) begin
        r_stat_mis <= r_stat_mis + STAT_W'(1);
      end
    end
  end

  assign stat_updates     = r_stat_upd;
  assign stat_mispredicts = r_stat_mis;
`endif

  // PC bits outside index/tag fields and upd_pred (default build) carry no state
  logic w_unused;
  assign w_unused = ^{upd_pred, lookup_pc[1:0], lookup_pc[DATA_W-1:TAG_HI+1],
                      upd_pc[1:0], upd_pc[DATA_W-1:TAG_HI+1]};

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
// ============================================================================
// Module  : tb_branch_target_buffer
// Scoreboard bench for branch_target_buffer: each stimulus step queues the
// expected lookup result, a monitor pops and compares on the falling edge.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_target_buffer;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              enable;
  logic [DATA_W-1:0] lookup_pc;
  logic              pred_taken;
  logic [DATA_W-1:0] pred_pc;
  logic              upd_valid;
  logic [DATA_W-1:0] upd_pc;
  logic              upd_taken;
  logic [DATA_W-1:0] upd_target;
  logic              upd_pred;
`ifdef BRANCH_TARGET_BUFFER_STATS_EN
  logic [31:0]       stat_updates;
  logic [31:0]       stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_target_buffer #(
    .DATA_W  (64),
    .ENTRIES (16),
    .TAG_W   (8),
    .CNT_W   (2)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .enable     (enable),
    .lookup_pc  (lookup_pc),
    .pred_taken (pred_taken),
    .pred_pc    (pred_pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_pred   (upd_pred)
`ifdef BRANCH_TARGET_BUFFER_STATS_EN
    ,
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct packed {
    logic              t;
    logic [DATA_W-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  logic lk_valid = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;

  // Monitor: compare the presented lookup against the oldest expectation
  always @(negedge clk) begin
    if (lk_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL step%0d scoreboard empty: taken=%0b pc=0x%0h", step_no, pred_taken, pred_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ((pred_taken !== e.t) || (pred_pc !== e.pc)) begin
          n_errors++;
          $display("FAIL step%0d lookup 0x%0h: got taken=%0b pc=0x%0h, expected taken=%0b pc=0x%0h",
                   step_no, lookup_pc, pred_taken, pred_pc, e.t, e.pc);
        end
      end
    end
  end

  // One cycle: drive lookup + optional update, queue expected (pre-update) lookup
  task automatic step(input logic [DATA_W-1:0] lpc, input logic et, input logic [DATA_W-1:0] epc,
                      input logic uv, input logic [DATA_W-1:0] upc, input logic ut,
                      input logic [DATA_W-1:0] utgt, input logic up, input logic en);
    step_no++;
    lookup_pc  = lpc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utgt;
    upd_pred   = up;
    enable     = en;
    lk_valid   = 1'b1;
    exp_q.push_back('{t: et, pc: epc});
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    arst_n = 1'b0; enable = 1'b0; lookup_pc = '0; upd_valid = 1'b0;
    upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred = 1'b0;
    @(posedge clk); #1;

    // Reset held: outputs zero, update discarded
    step(64'h100, 0, 64'h0,   1, 64'h100, 1, 64'h200, 0, 1);
    arst_n = 1'b1;
    step(64'h100, 0, 64'h0,   1, 64'h300, 0, 64'h0,   0, 1); // NT miss: no alloc
    step(64'h300, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0, 1);
    step(64'h100, 0, 64'h0,   1, 64'h100, 1, 64'h200, 0, 1); // same-cycle: no bypass
    step(64'h100, 1, 64'h200, 1, 64'h100, 1, 64'h998, 0, 0); // enable low: blocked
    step(64'h140, 0, 64'h0,   1, 64'h100, 0, 64'h0,   0, 1); // other tag; cnt 10->01
    step(64'h100, 0, 64'h0,   1, 64'h100, 1, 64'h200, 0, 1); // cnt 01->10
    step(64'h100, 1, 64'h200, 1, 64'h100, 1, 64'h280, 0, 1); // cnt ->11, tgt 0x280
    for (int k = 0; k < 4; k++)
      step(64'h100, 1, 64'h280, 1, 64'h100, 1, 64'h280, 0, 1); // saturate at 11
    step(64'h100, 1, 64'h280, 1, 64'h100, 0, 64'h0,   0, 1); // 11->10
    step(64'h100, 1, 64'h280, 1, 64'h100, 0, 64'h0,   0, 1); // 10->01
    step(64'h100, 0, 64'h0,   1, 64'h300, 0, 64'h0,   0, 1); // NT miss same index
    step(64'h100, 0, 64'h0,   1, 64'h100, 0, 64'h0,   0, 1); // 01->00
    step(64'h300, 0, 64'h0,   1, 64'h100, 0, 64'h0,   0, 1); // saturate at 00
    step(64'h100, 0, 64'h0,   1, 64'h100, 1, 64'h400, 0, 1); // 00->01, tgt 0x400
    step(64'h100, 0, 64'h0,   1, 64'h100, 1, 64'h400, 0, 1); // 01->10
    step(64'h100, 1, 64'h400, 1, 64'h104, 1, 64'h55C, 0, 1); // alloc index 1
    step(64'h104, 1, 64'h55C, 1, 64'h140, 1, 64'h777, 0, 1); // overwrite index 0
    step(64'h140, 1, 64'h777, 0, 64'h0,   0, 64'h0,   0, 1);
    step(64'h100, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0, 1);

    // Reset while table populated: outputs drop immediately
    arst_n = 1'b0;
    step(64'h140, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0, 1);
    arst_n = 1'b1;
`ifdef BRANCH_TARGET_BUFFER_STATS_EN
    chk("stat_updates after reset", 64'(stat_updates), 64'd0);
    chk("stat_mispredicts after reset", 64'(stat_mispredicts), 64'd0);
`endif
    step(64'h100, 0, 64'h0,   1, 64'h100, 1, 64'h200, 1, 1); // WT alloc
    step(64'h100, 1, 64'h200, 1, 64'h100, 0, 64'h0,   1, 1); // 10->01
    step(64'h100, 0, 64'h0,   1, 64'h100, 0, 64'h0,   1, 1); // 01->00
    step(64'h100, 0, 64'h0,   0, 64'h0,   0, 64'h0,   0, 1);
`ifdef BRANCH_TARGET_BUFFER_STATS_EN
    chk("stat_updates", 64'(stat_updates), 64'd3);
    chk("stat_mispredicts", 64'(stat_mispredicts), 64'd2);
    arst_n = 1'b0;
    #1;
    chk("stat_updates pulse reset", 64'(stat_updates), 64'd0);
    chk("stat_mispredicts pulse reset", 64'(stat_mispredicts), 64'd0);
    arst_n = 1'b1;
`endif

    lk_valid  = 1'b0;
    upd_valid = 1'b0;
    @(negedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
